fft_bfly_r2_pipe: RTL and testbench

Parametrised, fully pipelined radix-2 DIT complex butterfly, the successor to the 8-bit load/compute butterfly. Computes X0 = A + B·W and X1 = A − B·W on signed complex samples with a runtime-supplied twiddle. Accepts one butterfly per cycle under valid/ready flow control, with an optional per-butterfly divide-by-2 scaling stage. Sits between the FFT stage address generator/twiddle ROM and the stage ping-pong memory.

---
 rtl/fft_bfly_r2_pipe_if.sv | 34 +++
 rtl/fft_bfly_r2_pipe.sv | 161 ++++++++++++++++
 tb/tb_fft_bfly_r2_pipe.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_bfly_r2_pipe_if.sv
// Stream interface for the radix-2 butterfly: input operand set and output result set,
// each with its own valid/ready pair.
interface fft_bfly_r2_pipe_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned TW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] a_re;
  logic signed [DW-1:0] a_im;
  logic signed [DW-1:0] b_re;
  logic signed [DW-1:0] b_im;
  logic signed [TW-1:0] w_re;
  logic signed [TW-1:0] w_im;
  logic                 scale;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] x0_re;
  logic signed [DW-1:0] x0_im;
  logic signed [DW-1:0] x1_re;
  logic signed [DW-1:0] x1_im;
  logic                 ovf;
  logic [15:0]          ovf_cnt;

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, w_re, w_im, scale, out_ready,
    output in_ready, out_valid, x0_re, x0_im, x1_re, x1_im, ovf, ovf_cnt
  );

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, w_re, w_im, scale, out_ready,
    input  in_ready, out_valid, x0_re, x0_im, x1_re, x1_im, ovf, ovf_cnt
  );
endinterface

// File: rtl/fft_bfly_r2_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly with global-stall flow control and saturation.
// Define BFLY_OVF_CNT_EN to build the saturating overflow event counter behind ovf_cnt.
module fft_bfly_r2_pipe #(
  parameter int unsigned DW = 16,
  parameter int unsigned TW = 16
) (
  input logic               clk,
  input logic               rst,
  fft_bfly_r2_pipe_if.slave bus
);
  localparam int unsigned PW = DW + TW;
  localparam int unsigned SW = DW + 3;
  localparam logic signed [PW:0]   RndK = {{(DW + 2){1'b0}}, 1'b1, {(TW - 2){1'b0}}};
  localparam logic signed [SW-1:0] MaxV = {4'b0000, {(DW - 1){1'b1}}};
  localparam logic signed [SW-1:0] MinV = {4'b1111, {(DW - 1){1'b0}}};

  typedef struct packed {
    logic signed [DW-1:0] a_re;
    logic signed [DW-1:0] a_im;
    logic signed [DW-1:0] b_re;
    logic signed [DW-1:0] b_im;
    logic signed [TW-1:0] w_re;
    logic signed [TW-1:0] w_im;
    logic                 sc;
  } s1_t;

  typedef struct packed {
    logic signed [DW-1:0] a_re;
    logic signed [DW-1:0] a_im;
    logic signed [PW-1:0] p_rr;
    logic signed [PW-1:0] p_ii;
    logic signed [PW-1:0] p_ri;
    logic signed [PW-1:0] p_ir;
    logic                 sc;
  } s2_t;

  typedef struct packed {
    logic signed [DW-1:0] x0_re;
    logic signed [DW-1:0] x0_im;
    logic signed [DW-1:0] x1_re;
    logic signed [DW-1:0] x1_im;
    logic                 ovf;
  } s3_t;

  logic adv;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  s3_t  s3_q, s3_d, res;

  logic signed [PW:0]   pr_re, pr_im;
  logic signed [DW+1:0] bw_re, bw_im;
  logic [DW:0]          r0_re, r0_im, r1_re, r1_im;

  // Returns {saturated, value}; optional halving happens before the clamp.
  function automatic logic [DW:0] sat_scale(input logic signed [SW-1:0] s, input logic sc);
    logic signed [SW-1:0] t;
    t = sc ? ((s + SW'(1)) >>> 1) : s;
    if (t > MaxV) return {1'b1, MaxV[DW-1:0]};
    if (t < MinV) return {1'b1, MinV[DW-1:0]};
    return {1'b0, t[DW-1:0]};
  endfunction

  assign adv          = !v3_q || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    pr_re = (PW + 1)'($signed(s2_q.p_rr)) - (PW + 1)'($signed(s2_q.p_ii));
    pr_im = (PW + 1)'($signed(s2_q.p_ri)) + (PW + 1)'($signed(s2_q.p_ir));
    bw_re = (DW + 2)'((pr_re + RndK) >>> (TW - 1));
    bw_im = (DW + 2)'((pr_im + RndK) >>> (TW - 1));
    r0_re = sat_scale(SW'($signed(s2_q.a_re)) + SW'(bw_re), s2_q.sc);
    r0_im = sat_scale(SW'($signed(s2_q.a_im)) + SW'(bw_im), s2_q.sc);
    r1_re = sat_scale(SW'($signed(s2_q.a_re)) - SW'(bw_re), s2_q.sc);
    r1_im = sat_scale(SW'($signed(s2_q.a_im)) - SW'(bw_im), s2_q.sc);
    res.x0_re = r0_re[DW-1:0];
    res.x0_im = r0_im[DW-1:0];
    res.x1_re = r1_re[DW-1:0];
    res.x1_im = r1_im[DW-1:0];
    res.ovf   = r0_re[DW] | r0_im[DW] | r1_re[DW] | r1_im[DW];
  end

  // Whole pipe freezes on stall; data registers only load on valid slots.
  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;
    if (adv) begin
      v1_d = bus.in_valid;
      v2_d = v1_q;
      v3_d = v2_q;
      if (bus.in_valid) begin
        s1_d.a_re = bus.a_re;
        s1_d.a_im = bus.a_im;
        s1_d.b_re = bus.b_re;
        s1_d.b_im = bus.b_im;
        s1_d.w_re = bus.w_re;
        s1_d.w_im = bus.w_im;
        s1_d.sc   = bus.scale;
      end
      if (v1_q) begin
        s2_d.a_re = s1_q.a_re;
        s2_d.a_im = s1_q.a_im;
        s2_d.p_rr = PW'($signed(s1_q.b_re)) * PW'($signed(s1_q.w_re));
        s2_d.p_ii = PW'($signed(s1_q.b_im)) * PW'($signed(s1_q.w_im));
        s2_d.p_ri = PW'($signed(s1_q.b_re)) * PW'($signed(s1_q.w_im));
        s2_d.p_ir = PW'($signed(s1_q.b_im)) * PW'($signed(s1_q.w_re));
        s2_d.sc   = s1_q.sc;
      end
      if (v2_q) s3_d = res;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.x0_re     = s3_q.x0_re;
  assign bus.x0_im     = s3_q.x0_im;
  assign bus.x1_re     = s3_q.x1_re;
  assign bus.x1_im     = s3_q.x1_im;
  assign bus.ovf       = s3_q.ovf;

`ifdef BFLY_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (v3_q && bus.out_ready && s3_q.ovf && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_cnt_q <= '0;
    else      ovf_cnt_q <= ovf_cnt_d;
  end

  assign bus.ovf_cnt = ovf_cnt_q;
`else
  assign bus.ovf_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_fft_bfly_r2_pipe.sv
// Bench for fft_bfly_r2_pipe: directed vectors plus random streams scored against an
// integer-arithmetic butterfly model.
module tb_fft_bfly_r2_pipe;
  localparam int unsigned DW = 16;
  localparam int unsigned TW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_bfly_r2_pipe_if #(.DW(DW), .TW(TW)) bus ();
  fft_bfly_r2_pipe #(.DW(DW), .TW(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [DW-1:0] x0r;
    logic [DW-1:0] x0i;
    logic [DW-1:0] x1r;
    logic [DW-1:0] x1i;
    logic          ovf;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  res_t last_obs;
  bit   acc;
  int   ovf_model = 0;
  int   lat;
  int   sent;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint rnd(input longint p);
    return (p + (longint'(1) <<< (TW - 2))) >>> (TW - 1);
  endfunction

  function automatic void sat(input longint s, input bit sc, output logic [DW-1:0] v,
                              output bit o);
    longint t, mx, mn;
    mx = (longint'(1) <<< (DW - 1)) - 1;
    mn = -(longint'(1) <<< (DW - 1));
    t  = sc ? ((s + 1) >>> 1) : s;
    o  = (t > mx) || (t < mn);
    t  = (t > mx) ? mx : ((t < mn) ? mn : t);
    v  = t[DW-1:0];
  endfunction

  function automatic res_t model(input longint ar, ai, br, bi, wr, wi, input bit sc);
    res_t r;
    bit o0, o1, o2, o3;
    longint bwr, bwi;
    bwr = rnd(br * wr - bi * wi);
    bwi = rnd(br * wi + bi * wr);
    sat(ar + bwr, sc, r.x0r, o0);
    sat(ai + bwi, sc, r.x0i, o1);
    sat(ar - bwr, sc, r.x1r, o2);
    sat(ai - bwi, sc, r.x1i, o3);
    r.ovf = o0 | o1 | o2 | o3;
    return r;
  endfunction

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step();
    res_t cur, snap;
    bit   hold;
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (acc) begin
      exp_q.push_back(model(bus.a_re, bus.a_im, bus.b_re, bus.b_im, bus.w_re, bus.w_im,
                            bus.scale));
    end
    cur = {bus.x0_re, bus.x0_im, bus.x1_re, bus.x1_im, bus.ovf};
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 65'(bus.out_valid), 65'(0));
      end else begin
        check("out_data", cur, exp_q[0]);
        if (exp_q[0].ovf) ovf_model++;
        last_obs = cur;
        void'(exp_q.pop_front());
      end
    end
    hold = bus.out_valid && !bus.out_ready;
    snap = cur;
    @(posedge clk);
    #1;
    if (hold) begin
      check("stall_valid", 65'(bus.out_valid), 65'(1));
      check("stall_hold", {bus.x0_re, bus.x0_im, bus.x1_re, bus.x1_im, bus.ovf}, snap);
    end
  endtask

  task automatic send(input logic [15:0] ar, ai, br, bi, wr, wi, input bit sc);
    bus.a_re = ar; bus.a_im = ai; bus.b_re = br; bus.b_im = bi;
    bus.w_re = wr; bus.w_im = wi; bus.scale = sc; bus.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (acc) break;
    end
    check("send_accept", 65'(acc), 65'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && exp_q.size() > 0; k++) step();
    check("drain_empty", 65'(exp_q.size()), 65'(0));
  endtask

  task automatic rand_inputs();
    bus.a_re  = 16'($urandom);
    bus.a_im  = 16'($urandom);
    bus.b_re  = 16'($urandom);
    bus.b_im  = 16'($urandom);
    bus.w_re  = 16'($urandom);
    bus.w_im  = 16'($urandom);
    bus.scale = 1'($urandom_range(0, 1));
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.scale = 1'b0;
    bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0; bus.w_re = '0; bus.w_im = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 65'(bus.out_valid), 65'(0));
    check("rst_in_ready", 65'(bus.in_ready), 65'(1));
    check("rst_data", {bus.x0_re, bus.x0_im, bus.x1_re, bus.x1_im, bus.ovf}, 65'(0));
    check("rst_ovf_cnt", 65'(bus.ovf_cnt), 65'(0));
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Unity twiddle; latency counted with the acceptance cycle as cycle 0.
    send(16'd1000, 16'd0, 16'd500, 16'd0, 16'h7FFF, 16'd0, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 10) begin step(); lat++; end
    check("t1_latency", 65'(lat), 65'(3));
    drain();
    check("t1_out", last_obs, {16'd1500, 16'd0, 16'd500, 16'd0, 1'b0});

    send(16'd0, 16'd0, 16'd100, 16'd0, 16'd0, 16'h8000, 1'b0);
    drain();
    check("t2_minus_j", last_obs, {16'd0, 16'hFF9C, 16'd0, 16'd100, 1'b0});
    send(16'd0, 16'd0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0);
    drain();
    check("t2_fullscale", last_obs, {16'd0, 16'h7FFF, 16'd0, 16'h8000, 1'b1});

    send(16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 1'b0);
    drain();
    check("t3_sat", last_obs, {16'h7FFF, 16'd0, 16'd1, 16'd0, 1'b1});
    send(16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 1'b1);
    drain();
    check("t3_scaled", last_obs, {16'h7FFF, 16'd0, 16'd1, 16'd0, 1'b0});

    // Eight back-to-back samples with a three-cycle downstream stall.
    sent = 0;
    rand_inputs();
    for (int c = 0; c < 40; c++) begin
      if (sent == 8 && exp_q.size() == 0) break;
      bus.out_ready = !(c >= 4 && c < 7);
      bus.in_valid  = (sent < 8);
      step();
      if (acc) begin sent++; rand_inputs(); end
      if (c == 5) check("t4_in_ready_low", 65'(bus.in_ready), 65'(0));
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    check("t4_sent", 65'(sent), 65'(8));
    check("t4_all_out", 65'(exp_q.size()), 65'(0));

    // Random valid/ready patterns.
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      step();
      if (acc) rand_inputs();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drain();
`ifdef BFLY_OVF_CNT_EN
    check("ovf_cnt_random", 65'(bus.ovf_cnt), 65'((ovf_model > 65535) ? 65535 : ovf_model));
`else
    check("ovf_cnt_tied", 65'(bus.ovf_cnt), 65'(0));
`endif

    // Asynchronous reset with samples in flight.
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t5_async_valid", 65'(bus.out_valid), 65'(0));
    check("t5_async_data", {bus.x0_re, bus.x0_im, bus.x1_re, bus.x1_im, bus.ovf}, 65'(0));
    exp_q.delete();
    ovf_model = 0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_post_valid", 65'(bus.out_valid), 65'(0));
    send(16'd1234, 16'hFF00, 16'd4000, 16'h8123, 16'h5A82, 16'hA57E, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 10) begin step(); lat++; end
    check("t5_latency", 65'(lat), 65'(3));
    drain();

    // Five overflowing samples, one held in a two-cycle stall.
    for (int i = 0; i < 5; i++) begin
      bus.out_ready = (i != 2);
      send(16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 1'b0);
      if (i == 2) begin step(); step(); bus.out_ready = 1'b1; end
    end
    bus.out_ready = 1'b1;
    drain();
`ifdef BFLY_OVF_CNT_EN
    check("t6_ovf_cnt", 65'(bus.ovf_cnt), 65'(5));
    force dut.ovf_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.ovf_cnt_q;
    send(16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 1'b0);
    drain();
    check("t6_ovf_cnt_sat", 65'(bus.ovf_cnt), 65'(16'hFFFF));
`else
    check("t6_ovf_cnt_tied", 65'(bus.ovf_cnt), 65'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end
endmodule
